anton_neopixel_stream: RTL

// - WS2812 serialiser in the clk7mhz domain, directly downstream of the pixel buffer that the APB bus side writes.
// - Walks buffer bytes 0..BUFFER_END, reading one byte per 8 bit-slots, and emits them MSB first as NRZ high/low pulses on neoData.
// - Closes every frame with a low latch period, then pulses pixelsSync so software/bus side knows the frame was consumed.

---
 rtl/anton_neopixel_stream_pkg.sv | 23 ++
 rtl/anton_neopixel_bit_timer.sv | 58 +++++
 rtl/anton_neopixel_stream.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/anton_neopixel_stream_pkg.sv
// anton_neopixel_stream_pkg
//   Shared timing defaults and helpers for the WS2812 serialiser running in
//   the clk7mhz domain. All cycle counts are in 7 MHz clocks (~142.9 ns).
//   The state encodings stay local to the top module.
package anton_neopixel_stream_pkg;

  // Last buffer byte streamed per frame: 64 RGB pixels.
  localparam int BUFFER_END_DEFAULT   = 191;
  // One bit slot of 1.286 us.
  localparam int BIT_CYCLES_DEFAULT   = 9;
  // High time for a 0 bit (429 ns).
  localparam int T0H_CYCLES_DEFAULT   = 3;
  // High time for a 1 bit (857 ns).
  localparam int T1H_CYCLES_DEFAULT   = 6;
  // Low time that closes a frame (57 us, longer than the 50 us WS2812 reset).
  localparam int LATCH_CYCLES_DEFAULT = 400;

  // Number of high clocks at the start of a slot for the given bit value.
  function automatic int highCycles(input logic bitValue, input int t0h, input int t1h);
    return bitValue ? t1h : t0h;
  endfunction

endpackage

// File: rtl/anton_neopixel_bit_timer.sv
// anton_neopixel_bit_timer
//   Times one WS2812 bit slot. The slot starts high and drops low after
//   T0H_CYCLES or T1H_CYCLES clocks, depending on bitValue. neoData is a
//   flop, so the line is glitch-free.
// Ports
//   clk7mhz   in   clock
//   resetn    in   synchronous active-low reset
//   start     in   begin a new slot on the next clock; has priority over wrap
//   active    in   a slot is in progress (the owner is in its bit phase)
//   bitValue  in   value of the bit in the current slot (held stable for the slot)
//   neoData   out  registered serial line
//   slotDone  out  last clock of the current slot
module anton_neopixel_bit_timer
  import anton_neopixel_stream_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEFAULT,
  parameter int T0H_CYCLES = T0H_CYCLES_DEFAULT,
  parameter int T1H_CYCLES = T1H_CYCLES_DEFAULT
) (
  input  logic clk7mhz,
  input  logic resetn,
  input  logic start,
  input  logic active,
  input  logic bitValue,
  output logic neoData,
  output logic slotDone
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cycleCnt;
  logic [CW-1:0] cycleNext;
  logic [CW-1:0] highLen;

  assign cycleNext = cycleCnt + CW'(1);
  assign highLen   = CW'(highCycles(bitValue, T0H_CYCLES, T1H_CYCLES));
  assign slotDone  = active && (cycleCnt == LAST_CYCLE);

  // neoData is computed one clock ahead from cycleNext, so the registered
  // line lines up with cycleCnt. Every slot begins high (T0H_CYCLES >= 1).
  always_ff @(posedge clk7mhz) begin
    if (!resetn) begin
      cycleCnt <= '0;
      neoData  <= 1'b0;
    end else if (start) begin
      cycleCnt <= '0;
      neoData  <= 1'b1;
    end else if (active && !slotDone) begin
      cycleCnt <= cycleNext;
      neoData  <= (cycleNext < highLen);
    end else begin
      cycleCnt <= '0;
      neoData  <= 1'b0;
    end
  end

endmodule

// File: rtl/anton_neopixel_stream.sv
// anton_neopixel_stream
//   WS2812 serialiser that streams buffer bytes 0..BUFFER_END MSB first as
//   NRZ pulses. Each frame is closed by a low latch period, and pixelsSync
//   pulses on the last latch clock. The next byte is prefetched during the
//   current byte, so only the first byte of a frame pays the 2-clock fetch.
//   Frame length: 2 + (BUFFER_END+1)*8*BIT_CYCLES + LATCH_CYCLES clocks.
//   Legal parameters: T0H_CYCLES < T1H_CYCLES < BIT_CYCLES,
//   BUFFER_END < 16384, LATCH_CYCLES >= 2.
// Ports
//   clk7mhz     in   clock
//   resetn      in   synchronous active-low reset
//   enable      in   1 = stream back to back; 0 = stop after the current frame
//   pixelAddr   out  buffer read address (registered)
//   pixelData   in   buffer read data, valid 1 clock after pixelAddr changes
//   neoData     out  WS2812 serial line (registered)
//   neoState    out  1 while bit slots are driven
//   pixelsSync  out  1-clock pulse on the last latch clock
module anton_neopixel_stream
  import anton_neopixel_stream_pkg::*;
#(
  parameter int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter int BIT_CYCLES   = BIT_CYCLES_DEFAULT,
  parameter int T0H_CYCLES   = T0H_CYCLES_DEFAULT,
  parameter int T1H_CYCLES   = T1H_CYCLES_DEFAULT,
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEFAULT
) (
  input  logic        clk7mhz,
  input  logic        resetn,
  input  logic        enable,
  output logic [13:0] pixelAddr,
  input  logic [7:0]  pixelData,
  output logic        neoData,
  output logic        neoState,
  output logic        pixelsSync
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_BITS,
    S_LATCH
  } state_t;

  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [13:0]   ADDR_END   = 14'(BUFFER_END);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [LW-1:0] LATCH_PRE  = LW'(LATCH_CYCLES - 2);

  state_t        state;
  logic [7:0]    shiftReg;
  logic [2:0]    bitCnt;
  logic          fetchCnt;
  logic          lastByte;   // byte in shiftReg came from ADDR_END
  logic [LW-1:0] latchCnt;

  logic          slotDone;
  logic          startSlot;
  logic          frameDone;
  logic [13:0]   nextAddr;

  // The final slot of the frame does not restart the timer, so the line
  // stays low when the FSM moves into the latch period.
  assign frameDone = slotDone && (bitCnt == 3'd0) && lastByte;
  assign startSlot = ((state == S_FETCH) && fetchCnt) ||
                     ((state == S_BITS) && slotDone && !frameDone);
  assign nextAddr  = (pixelAddr == ADDR_END) ? 14'd0 : pixelAddr + 14'd1;

  anton_neopixel_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) uBitTimer (
    .clk7mhz  (clk7mhz),
    .resetn   (resetn),
    .start    (startSlot),
    .active   (state == S_BITS),
    .bitValue (shiftReg[7]),
    .neoData  (neoData),
    .slotDone (slotDone)
  );

  always_ff @(posedge clk7mhz) begin
    if (!resetn) begin
      state      <= S_IDLE;
      shiftReg   <= '0;
      bitCnt     <= '0;
      fetchCnt   <= 1'b0;
      lastByte   <= 1'b0;
      latchCnt   <= '0;
      pixelAddr  <= '0;
      neoState   <= 1'b0;
      pixelsSync <= 1'b0;
    end else begin
      pixelsSync <= 1'b0;
      case (state)
        S_IDLE: begin
          neoState <= 1'b0;
          if (enable) begin
            state     <= S_FETCH;
            pixelAddr <= '0;
            fetchCnt  <= 1'b0;
          end
        end

        // Clock 0 presents the address. On clock 1 the data is back; it is
        // loaded and the address moves on to prefetch the next byte.
        S_FETCH: begin
          fetchCnt <= 1'b1;
          if (fetchCnt) begin
            shiftReg  <= pixelData;
            bitCnt    <= 3'd7;
            lastByte  <= (pixelAddr == ADDR_END);
            pixelAddr <= nextAddr;
            neoState  <= 1'b1;
            state     <= S_BITS;
          end
        end

        S_BITS: begin
          if (slotDone) begin
            if (bitCnt != 3'd0) begin
              shiftReg <= {shiftReg[6:0], 1'b0};
              bitCnt   <= bitCnt - 3'd1;
            end else if (!lastByte) begin
              // The prefetched byte has been stable since early in the
              // previous byte, so there is no gap between bytes.
              shiftReg  <= pixelData;
              bitCnt    <= 3'd7;
              lastByte  <= (pixelAddr == ADDR_END);
              pixelAddr <= nextAddr;
            end else begin
              state    <= S_LATCH;
              neoState <= 1'b0;
              latchCnt <= '0;
            end
          end
        end

        S_LATCH: begin
          latchCnt <= latchCnt + LW'(1);
          // pixelsSync is registered, so it is raised one clock early to
          // land on the last latch clock.
          if (latchCnt == LATCH_PRE)
            pixelsSync <= 1'b1;
          if (latchCnt == LATCH_LAST) begin
            latchCnt  <= '0;
            pixelAddr <= '0;
            fetchCnt  <= 1'b0;
            state     <= enable ? S_FETCH : S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
